// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall vectors, flag levels
// and INT sequencing state encodings.
package pipe_ctrl_pkg;

   localparam int ADDR_W  = 16;
   localparam int STALL_W = 6;
   localparam int CNT_W   = 16;

   localparam logic [STALL_W-1:0] StallNone    = 6'b000000;
   localparam logic [STALL_W-1:0] StallLoadUse = 6'b000111;
   localparam logic [STALL_W-1:0] StallInt     = 6'b000011;
   localparam logic [STALL_W-1:0] StallFetch   = 6'b000001;

   localparam logic StallYes      = 1'b1;
   localparam logic StallNo       = 1'b0;
   localparam logic BranchFlagUp  = 1'b1;
   localparam logic BranchFlagDown = 1'b0;
   localparam logic RstEnable     = 1'b0;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   typedef enum logic {
      INT_IDLE = 1'b0,
      INT_SAVE = 1'b1
   } int_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector arbitration, IF/ID flush, PC redirect with a
// pending-branch holding register, and the two-phase INT sequencer.
//
// state    | meaning
// INT_IDLE | no INT in flight; a phase-1 request stalls PC and IF/ID
// INT_SAVE | INT2 sits in ID; return to idle once IF/ID advances
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_stall_req,
   input  logic              id_stall_req_int,
   input  logic              id_branch_flag,
   input  logic [ADDR_W-1:0] id_branch_addr,
   input  logic              mem_stall_req,
   output logic [STALL_W-1:0] stall,
   output logic              flush_ifid,
   output logic              pc_branch_flag,
   output logic [ADDR_W-1:0] pc_branch_addr,
   output logic              int_state,
   output logic [CNT_W-1:0]  stall_cnt
);

   int_state_e        int_q, int_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              branch_acc;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         int_q        <= INT_IDLE;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         cnt_q        <= '0;
      end else begin
         int_q        <= int_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      stall          = StallNone;
      flush_ifid     = 1'b0;
      pc_branch_flag = BranchFlagDown;
      pc_branch_addr = '0;
      int_d          = int_q;
      pend_valid_d   = pend_valid_q;
      pend_addr_d    = pend_addr_q;
      cnt_d          = cnt_q;
      branch_acc     = 1'b0;

      if (rst != RstEnable) begin
         // A load-use stall wins outright: the branch operand is not valid yet.
         if (id_stall_req)
            stall = StallLoadUse;
         else if (id_stall_req_int && (int_q == INT_IDLE))
            stall = StallInt;
         else if (mem_stall_req)
            stall = StallFetch;

         flush_ifid = mem_stall_req & ~stall[1];
         branch_acc = id_branch_flag & ~id_stall_req;

         if (stall[0] == StallYes) begin
            if (branch_acc) begin
               pend_valid_d = 1'b1;
               pend_addr_d  = id_branch_addr;
            end
         end else if (pend_valid_q) begin
            pc_branch_flag = BranchFlagUp;
            pc_branch_addr = pend_addr_q;
            pend_valid_d   = 1'b0;
         end else if (branch_acc) begin
            pc_branch_flag = BranchFlagUp;
            pc_branch_addr = id_branch_addr;
         end

         case (int_q)
            INT_IDLE: if (id_stall_req_int && !id_stall_req) int_d = INT_SAVE;
            INT_SAVE: if (stall[1] == StallNo) int_d = INT_IDLE;
            default:  int_d = INT_IDLE;
         endcase

         if ((stall[0] == StallYes) && (cnt_q != CntMax))
            cnt_d = cnt_q + 1'b1;
      end
   end

   assign int_state = int_q;
   assign stall_cnt = cnt_q;

endmodule
